pwmled_bank: RTL

PWMLED_BANK -- requirements
Module: pwmled_bank

---
 rtl/pwmled_pkg.sv | 38 +++
 rtl/pwmled_if.sv | 29 ++
 rtl/pwm_fader.sv | 60 ++++++
 rtl/pwmled_bank.sv | 113 +++++++++++
 4 files changed

// File: rtl/pwmled_pkg.sv
// ============================================================================
// Module : pwmled_pkg
// Brief  : Shared register layout, field offsets and bit-reverse helper for
//          the RGB PWM LED bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwmled_pkg;

  localparam int c_REG_W  = 32;
  localparam int c_MAX_PW = 16;

  typedef enum logic [1:0] {
    COL_BLUE  = 2'd0,
    COL_GREEN = 2'd1,
    COL_RED   = 2'd2
  } colour_e;

  // Lowest bit of a colour field inside the 32-bit LED register.
  function automatic int field_lo(input colour_e col, input int pw);
    return int'(col) * pw;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [c_MAX_PW-1:0] bit_reverse(input logic [c_MAX_PW-1:0] v,
                                                      input int w);
    logic [c_MAX_PW-1:0] r;
    r = '0;
    for (int i = 0; i < c_MAX_PW; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwmled_if.sv
// ============================================================================
// Module : pwmled_if
// Brief  : Single-cycle strobe/ack register bus of the PWM LED bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwmled_if #(
  parameter int AW = 2
) ();
  logic          i_stb;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_data;
  logic          o_ack;
  logic [31:0]   o_data;

  modport master (
    output i_stb, i_we, i_addr, i_data,
    input  o_ack, o_data
  );

  modport slave (
    input  i_stb, i_we, i_addr, i_data,
    output o_ack, o_data
  );
endinterface

`default_nettype wire

// File: rtl/pwm_fader.sv
// ============================================================================
// Module : pwm_fader
// Brief  : One colour channel: target/current registers and PWM compare.
//          Fading toward the target is built only with PWMLED_FADE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_fader #(
  parameter int PW = 9
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  input  wire logic          i_load,
  input  wire logic [PW-1:0] i_value,
`ifdef PWMLED_FADE_EN
  input  wire logic          i_tick,
`endif
  input  wire logic [PW-1:0] i_cnt_rev,
  output logic      [PW-1:0] o_target,
  output logic               o_led
);

  logic [PW-1:0] r_target;
  logic [PW-1:0] r_current;
  logic [PW-1:0] w_current_nx;
  logic          r_led;

  always_comb begin
    w_current_nx = r_current;
`ifdef PWMLED_FADE_EN
    // Steps use the target as it stood before this edge, so a coinciding
    // write only steers the following tick.
    if (i_tick) begin
      if (r_current < r_target)      w_current_nx = r_current + PW'(1);
      else if (r_current > r_target) w_current_nx = r_current - PW'(1);
    end
`else
    if (i_load) w_current_nx = i_value;
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_target  <= '0;
      r_current <= '0;
      r_led     <= 1'b0;
    end else begin
      if (i_load) r_target <= i_value;
      r_current <= w_current_nx;
      r_led     <= (i_cnt_rev < r_current);
    end
  end

  assign o_target = r_target;
  assign o_led    = r_led;

endmodule

`default_nettype wire

// File: rtl/pwmled_bank.sv
// ============================================================================
// Module : pwmled_bank
// Brief  : Bank of NLED RGB LEDs with bit-reversed PWM and register bus.
//          Define PWMLED_FADE_EN to fade current values toward targets.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwmled_bank
  import pwmled_pkg::*;
#(
  parameter int NLED      = 4,
  parameter int PW        = 9,
  parameter int FADE_LOG2 = 16
) (
  input  wire logic              i_clk,
  input  wire logic              i_reset,
  pwmled_if.slave                bus,
  output logic [3*NLED-1:0]      o_led
);

  localparam int c_AW    = (NLED > 1) ? $clog2(NLED) : 1;
  localparam int c_NCH   = 3 * NLED;
  localparam int c_DEPTH = 1 << c_AW;

  logic [PW-1:0]       r_cnt;
  logic [PW-1:0]       w_cnt_rev;
  logic                w_wr;
  logic [NLED-1:0]     w_load;
  logic [c_NCH*PW-1:0] w_target;
  logic [31:0]         w_words [c_DEPTH];
  logic                r_ack;
  logic [31:0]         r_data;
  logic                w_unused_data;

  assign w_unused_data = ^bus.i_data[c_REG_W-1:3*PW];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_cnt <= '0;
    else         r_cnt <= r_cnt + PW'(1);
  end

  assign w_cnt_rev = PW'(bit_reverse(c_MAX_PW'(r_cnt), PW));

`ifdef PWMLED_FADE_EN
  logic [FADE_LOG2-1:0] r_presc;
  logic                 r_tick;

  // Tick is high for the one cycle in which the prescaler reads zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= r_presc + FADE_LOG2'(1);
      r_tick  <= &r_presc;
    end
  end
`else
  localparam int c_unused_fade_log2 = FADE_LOG2;
`endif

  assign w_wr = bus.i_stb && bus.i_we && (32'(bus.i_addr) < 32'(NLED));

  for (genvar k = 0; k < NLED; k++) begin : g_load
    assign w_load[k] = w_wr && (bus.i_addr == c_AW'(k));
  end

  for (genvar f = 0; f < c_NCH; f++) begin : g_fader
    localparam int c_LED = f / 3;
    localparam int c_LO  = field_lo(colour_e'(f % 3), PW);

    pwm_fader #(
      .PW(PW)
    ) u_fader (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load[c_LED]),
      .i_value   (bus.i_data[c_LO +: PW]),
`ifdef PWMLED_FADE_EN
      .i_tick    (r_tick),
`endif
      .i_cnt_rev (w_cnt_rev),
      .o_target  (w_target[f*PW +: PW]),
      .o_led     (o_led[f])
    );
  end

  // Address space is padded to a power of two; unpopulated slots read zero.
  for (genvar k = 0; k < c_DEPTH; k++) begin : g_word
    if (k < NLED) begin : g_led
      assign w_words[k] = 32'(w_target[k*3*PW +: 3*PW]);
    end else begin : g_empty
      assign w_words[k] = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ack  <= 1'b0;
      r_data <= '0;
    end else begin
      r_ack <= bus.i_stb;
      if (bus.i_stb && !bus.i_we) r_data <= w_words[bus.i_addr];
    end
  end

  assign bus.o_ack  = r_ack;
  assign bus.o_data = r_data;

endmodule

`default_nettype wire
